// File: rtl/auth_response_serializer_pkg.sv
// Shared defines, FSM encoding and helpers for auth_response_serializer.
// Build option AUTH_SER_LEN_PREFIX_EN adds the LENGTH state (2-byte little-endian length).
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 4
`endif
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 8
`endif
`ifndef MSG_LEN
`define MSG_LEN 96
`endif
`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif
`ifndef AUTH_ERROR_CMD
`define AUTH_ERROR_CMD 8'h7F
`endif
`ifndef ERR_INVALID_REQUEST
`define ERR_INVALID_REQUEST 8'h01
`endif

package auth_response_serializer_pkg;

`ifdef AUTH_SER_LEN_PREFIX_EN
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        HEADER  = 3'b001,
        PAYLOAD = 3'b010,
        DONE    = 3'b011,
        LENGTH  = 3'b100
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEADER  = 2'b01,
        PAYLOAD = 2'b10,
        DONE    = 2'b11
    } state_t;
`endif

    typedef enum logic [1:0] {
        SEL_HDR = 2'd0,
        SEL_LEN = 2'd1,
        SEL_PAY = 2'd2
    } byte_sel_t;

    localparam logic [31:0] ERR_HDR = {`PROTOCOL_VERSION, `AUTH_ERROR_CMD, `ERR_INVALID_REQUEST, 8'h00};

    function automatic logic [15:0] clamp_len(input logic [15:0] req, input logic [15:0] max_len);
        return (req > max_len) ? max_len : req;
    endfunction

endpackage

// File: rtl/auth_response_serializer_byte_mux.sv
// auth_byte_mux: combinational selector picking one byte of the snapshot (header, length or
// payload) by byte index. Header and payload are both read MSB-first.
module auth_byte_mux
    import auth_response_serializer_pkg::*;
#(
    parameter int HDR_BYTES     = 4,
    parameter int PAYLOAD_W     = 64,
    parameter int PAYLOAD_BYTES = PAYLOAD_W / 8
) (
    input  logic [HDR_BYTES*8-1:0] header_snap,
    input  logic [PAYLOAD_W-1:0]   payload_snap,
    input  logic [15:0]            len,
    input  byte_sel_t              sel,
    input  logic [15:0]            idx,
    output logic [7:0]             data
);

    always_comb begin
        data = 8'h00;
        case (sel)
            SEL_HDR: begin
                for (int i = 0; i < HDR_BYTES; i++)
                    if (idx == 16'(i)) data = header_snap[8*(HDR_BYTES-1-i) +: 8];
            end
            SEL_LEN: data = (idx == 16'd1) ? len[15:8] : len[7:0];
            SEL_PAY: begin
                for (int i = 0; i < PAYLOAD_BYTES; i++)
                    if (idx == 16'(i)) data = payload_snap[PAYLOAD_W-1-8*i -: 8];
            end
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/auth_response_serializer.sv
// Snapshots a certificate answer on the Ack_in rising edge and streams it as bytes over
// valid/ready. AUTH_SER_LEN_PREFIX_EN inserts a 2-byte little-endian length after the header.
module auth_response_serializer
    import auth_response_serializer_pkg::*;
#(
    parameter int HDR_BYTES     = `SIZE_OF_HEADER_IN_BYTES,
    parameter int PAYLOAD_W     = `MSG_LEN-(`SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES),
    parameter int PAYLOAD_BYTES = PAYLOAD_W / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [HDR_BYTES*8-1:0] header,
    input  logic [PAYLOAD_W-1:0]   payload,
    input  logic [15:0]            wLength,
    input  logic                   Ack_in,
    input  logic                   Error_Invalid_Request,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   busy,
    output logic                   Resp_Sent,
    output logic                   len_clamped
);

    localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);
    localparam logic [15:0] MAX_LEN  = 16'(PAYLOAD_BYTES);

    state_t                 state;
    logic [15:0]            cnt;
    logic [15:0]            len;
    logic [HDR_BYTES*8-1:0] header_snap;
    logic [PAYLOAD_W-1:0]   payload_snap;
    logic                   ack_q;
    logic                   armed;
    byte_sel_t              sel;
    logic [7:0]             mux_byte;
    logic                   accept;
    logic                   ack_rise;
    logic                   hdr_end;

    assign accept   = tx_valid && tx_ready;
    // armed blocks a false edge when Ack_in is already high as reset releases
    assign ack_rise = Ack_in && !ack_q && armed;
    assign hdr_end  = (cnt == HDR_LAST);

    always_comb begin
        sel     = SEL_HDR;
        tx_last = 1'b0;
        case (state)
            HEADER: begin
                sel = SEL_HDR;
`ifndef AUTH_SER_LEN_PREFIX_EN
                tx_last = hdr_end && (len == 16'd0);
`endif
            end
`ifdef AUTH_SER_LEN_PREFIX_EN
            LENGTH: begin
                sel     = SEL_LEN;
                tx_last = (cnt == 16'd1) && (len == 16'd0);
            end
`endif
            PAYLOAD: begin
                sel     = SEL_PAY;
                tx_last = (cnt == len - 16'd1);
            end
            default: ;
        endcase
        tx_last = tx_last && tx_valid;
    end

    auth_byte_mux #(
        .HDR_BYTES    (HDR_BYTES),
        .PAYLOAD_W    (PAYLOAD_W),
        .PAYLOAD_BYTES(PAYLOAD_BYTES)
    ) u_mux (
        .header_snap (header_snap),
        .payload_snap(payload_snap),
        .len         (len),
        .sel         (sel),
        .idx         (cnt),
        .data        (mux_byte)
    );

    assign tx_data = tx_valid ? mux_byte : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            header_snap  <= '0;
            payload_snap <= '0;
            ack_q        <= 1'b0;
            armed        <= 1'b0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            Resp_Sent    <= 1'b0;
            len_clamped  <= 1'b0;
        end else begin
            ack_q <= Ack_in;
            armed <= armed | ~Ack_in;
            case (state)
                IDLE: if (ack_rise) begin
                    if (Error_Invalid_Request) begin
                        header_snap <= (HDR_BYTES*8)'(ERR_HDR);
                        len         <= '0;
                        len_clamped <= 1'b0;
                    end else begin
                        header_snap <= header;
                        len         <= clamp_len(wLength, MAX_LEN);
                        len_clamped <= (wLength > MAX_LEN);
                    end
                    payload_snap <= payload;
                    cnt          <= '0;
                    tx_valid     <= 1'b1;
                    busy         <= 1'b1;
                    state        <= HEADER;
                end
                HEADER: if (accept) begin
                    if (hdr_end) begin
                        cnt <= '0;
`ifdef AUTH_SER_LEN_PREFIX_EN
                        state <= LENGTH;
`else
                        if (len != 16'd0) begin
                            state <= PAYLOAD;
                        end else begin
                            tx_valid  <= 1'b0;
                            Resp_Sent <= 1'b1;
                            state     <= DONE;
                        end
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`ifdef AUTH_SER_LEN_PREFIX_EN
                LENGTH: if (accept) begin
                    if (cnt == 16'd1) begin
                        cnt <= '0;
                        if (len != 16'd0) begin
                            state <= PAYLOAD;
                        end else begin
                            tx_valid  <= 1'b0;
                            Resp_Sent <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                PAYLOAD: if (accept) begin
                    if (cnt == len - 16'd1) begin
                        tx_valid  <= 1'b0;
                        Resp_Sent <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    Resp_Sent <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auth_response_serializer.sv
// Randomized bench for auth_response_serializer: each message's byte stream is predicted
// as a queue from header/length/payload rules and compared byte by byte under backpressure.
module tb_auth_response_serializer;

    localparam int HB  = `SIZE_OF_HEADER_IN_BYTES;
    localparam int PW  = `MSG_LEN-(`SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES);
    localparam int PB  = PW / 8;
`ifdef AUTH_SER_LEN_PREFIX_EN
    localparam int PRE = HB + 2;
`else
    localparam int PRE = HB;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HB*8-1:0] header = '0;
    logic [PW-1:0] payload = '0;
    logic [15:0]   wLength = '0;
    logic          Ack_in = 1'b0;
    logic          Error_Invalid_Request = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          tx_last;
    logic          busy;
    logic          Resp_Sent;
    logic          len_clamped;

    int n_chk = 0;
    int n_err = 0;

    auth_response_serializer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .header               (header),
        .payload              (payload),
        .wLength              (wLength),
        .Ack_in               (Ack_in),
        .Error_Invalid_Request(Error_Invalid_Request),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .tx_last              (tx_last),
        .busy                 (busy),
        .Resp_Sent            (Resp_Sent),
        .len_clamped          (len_clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pay();
        logic [PW-1:0] p;
        for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    function automatic logic [HB*8-1:0] rand_hdr();
        logic [HB*8-1:0] h;
        for (int i = 0; i < HB*8; i++) h[i] = 1'($urandom_range(0, 1));
        return h;
    endfunction

    // Raises Ack_in, then follows the stream until Resp_Sent; returns with Ack_in high.
    task automatic send(input logic [HB*8-1:0] h, input logic [PW-1:0] p, input logic [15:0] wl,
                        input bit err, input bit rnd_rdy, input int stall_at, input int rst_at,
                        input bit toggle);
        logic [7:0]      q[$];
        logic [15:0]     l;
        logic [31:0]     err_word;
        logic [HB*8-1:0] eh;
        int idx, vcyc, stall, cyc;
        err_word = {`PROTOCOL_VERSION, 8'h7F, 8'h01, 8'h00};
        eh = err ? (HB*8)'(err_word) : h;
        l  = err ? 16'd0 : ((wl > 16'(PB)) ? 16'(PB) : wl);
        for (int i = 0; i < HB; i++) q.push_back(eh[8*(HB-1-i) +: 8]);
`ifdef AUTH_SER_LEN_PREFIX_EN
        q.push_back(l[7:0]);
        q.push_back(l[15:8]);
`endif
        for (int i = 0; i < int'(l); i++) q.push_back(p[PW-1-8*i -: 8]);

        @(negedge clk);
        header = h; payload = p; wLength = wl; Error_Invalid_Request = err;
        Ack_in = 1'b1; tx_ready = 1'b1;
        idx = 0; vcyc = 0; stall = 0; cyc = 0;
        @(negedge clk);
        chk("busy_start", 32'(busy), 32'd1);
        chk("clamp", 32'(len_clamped), 32'(!err && (wl > 16'(PB))));
        // upstream changes must not leak into the message in flight
        header = rand_hdr(); payload = rand_pay(); wLength = 16'($urandom);
        Error_Invalid_Request = 1'($urandom_range(0, 1));
        while (idx < q.size() && cyc < 400) begin
            chk("valid", 32'(tx_valid), 32'd1);
            chk("data", 32'(tx_data), 32'(q[idx]));
            chk("last", 32'(tx_last), 32'(idx == q.size() - 1));
            if (tx_valid) vcyc++;
            if (rst_at == idx) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(tx_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_data", 32'(tx_data), 32'd0);
                chk("rst_clamp", 32'(len_clamped), 32'd0);
                return;
            end
            Ack_in = (toggle && cyc == 1) ? 1'b0 : 1'b1;
            if (stall_at == idx && stall < 3) begin
                tx_ready = 1'b0;
                stall++;
            end else begin
                tx_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (tx_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        chk("bytes_sent", 32'(idx), 32'(q.size()));
        chk("done_valid", 32'(tx_valid), 32'd0);
        chk("resp", 32'(Resp_Sent), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        if (!rnd_rdy) chk("cycles", 32'(vcyc), 32'(q.size() + stall));
        @(negedge clk);
        chk("resp_clr", 32'(Resp_Sent), 32'd0);
        chk("busy_clr", 32'(busy), 32'd0);
        chk("idle_valid", 32'(tx_valid), 32'd0);
    endtask

    task automatic hold_idle(input int n, input string tag);
        int act;
        act = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx_valid || busy || Resp_Sent) act++;
        end
        chk(tag, 32'(act), 32'd0);
    endtask

    initial begin
        logic [PW-1:0] p;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_resp", 32'(Resp_Sent), 32'd0);
        chk("rst_len_clamped", 32'(len_clamped), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        p = rand_pay();
        p[PW-1 -: 24] = 24'hAABBCC;
        send(32'h01020000, p, 16'd3, 1'b0, 1'b0, -1, -1, 1'b0);
        Ack_in = 1'b0;
        send(32'h01020000, p, 16'd3, 1'b0, 1'b0, 2, -1, 1'b0);
        Ack_in = 1'b0;
        send(rand_hdr(), rand_pay(), 16'd5, 1'b1, 1'b0, -1, -1, 1'b0);
        Ack_in = 1'b0;
        send(rand_hdr(), rand_pay(), 16'hFFFF, 1'b0, 1'b0, -1, -1, 1'b0);
        Ack_in = 1'b0;
        send(rand_hdr(), rand_pay(), 16'd0, 1'b0, 1'b0, -1, -1, 1'b0);
        Ack_in = 1'b0;
        send(rand_hdr(), rand_pay(), 16'hFFFF, 1'b0, 1'b0, -1, PRE + 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_idle(10, "after_reset_quiet");
        Ack_in = 1'b0;
        send(rand_hdr(), rand_pay(), 16'd4, 1'b0, 1'b1, -1, -1, 1'b0);
        hold_idle(30, "held_ack_quiet");

        for (int k = 0; k < 25; k++) begin
            Ack_in = 1'b0;
            send(rand_hdr(), rand_pay(), 16'($urandom_range(0, PB + 4)),
                 ($urandom_range(0, 7) == 0), 1'b1, -1, -1, 1'($urandom_range(0, 1)));
        end
        Ack_in = 1'b0;
        hold_idle(5, "final_quiet");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/auth_response_serializer.md
Name: auth_response_serializer

Overview:
- Downstream stage of the certificate-answer block. Snapshots its parallel response (header, payload, wLength, error flag) on the Ack_in rising edge.
- Streams the response out as bytes over a valid/ready interface to the USB endpoint TX buffer, header first, then payload MSB-first.
- On an invalid request it emits a 4-byte error message instead of the answer.

Parameters:
- HDR_BYTES, default `SIZE_OF_HEADER_IN_BYTES (4): header length in bytes.
- PAYLOAD_W, default `MSG_LEN-(`SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES): payload input width in bits.
- PAYLOAD_BYTES, default PAYLOAD_W/8: maximum payload bytes sent.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- header  in  HDR_BYTES*8  answer header {version, cmd, Param1, 8'h00}
- payload  in  PAYLOAD_W  answer payload, first byte at MSB
- wLength  in  16  payload byte count to send
- Ack_in  in  1  answer valid (level, held while upstream Enable is high)
- Error_Invalid_Request  in  1  upstream rejected the request
- tx_data  out  8  output byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts a byte when tx_valid&&tx_ready
- tx_last  out  1  marks the final byte of the message
- busy  out  1  message being serialized
- Resp_Sent  out  1  one-cycle pulse after the last byte is accepted
- len_clamped  out  1  sticky per message: wLength exceeded PAYLOAD_BYTES

Behaviour:
- Reset (async, any state): state=IDLE. tx_data=0, tx_valid=0, tx_last=0, busy=0, Resp_Sent=0, len_clamped=0, snapshot registers cleared, Ack_in edge register=0.
- FSM states: IDLE, HEADER, PAYLOAD, DONE.
- IDLE: on Ack_in rising edge (Ack_in=1, previous sample 0), capture the response and go to HEADER.
  - Normal capture: header, payload, len=min(wLength,PAYLOAD_BYTES). len_clamped=1 if wLength>PAYLOAD_BYTES, else 0.
  - If Error_Invalid_Request=1 at capture: header_snap={`PROTOCOL_VERSION, `AUTH_ERROR_CMD, `ERR_INVALID_REQUEST, 8'h00}, len=0.
  - busy=1 from the cycle after the edge.
  - Ack_in held high never retriggers; a new message needs Ack_in to go low then high.
- Output timing: first tx_valid is asserted the cycle after the capture edge (latency 1). Bytes go out back-to-back at one per cycle while tx_ready=1.
- HEADER: sends header bytes MSB first, byte index 0..HDR_BYTES-1.
  - After the last header byte is accepted: go to PAYLOAD if len!=0, else DONE.
  - If len==0, tx_last=1 on header byte HDR_BYTES-1.
- PAYLOAD: byte i = payload_snap[PAYLOAD_W-1-8i -: 8], for i=0..len-1.
  - tx_last=1 on byte len-1.
  - Byte counter is 16 bits and never wraps past len.
- Handshake: while tx_valid=1 and tx_ready=0, tx_data, tx_valid and tx_last hold stable. tx_valid never drops before acceptance.
- DONE: tx_valid=0; Resp_Sent=1 for exactly one cycle; busy=0 next cycle; return to IDLE.
- Ack_in activity while busy: a rising edge is ignored and the edge detector keeps sampling. Changes on the upstream inputs while busy have no effect, because the snapshot is used.
- Simultaneous events: the Ack_in edge in the same cycle as the DONE→IDLE transition is ignored. Upstream must drop Ack_in between messages.

Optional Feature:
- Macro: AUTH_SER_LEN_PREFIX_EN.
- Defined: state LENGTH is added between HEADER and PAYLOAD. It always sends 2 bytes of len, little-endian (len[7:0] then len[15:8]). tx_last moves to the second length byte when len==0.
- Undefined: no length bytes; HEADER goes directly to PAYLOAD or DONE.

Decomposition:
- Shared package/defines file:
  - `PROTOCOL_VERSION and `SIZE_OF_HEADER_* (existing).
  - New: `AUTH_ERROR_CMD = 8'h7F, `ERR_INVALID_REQUEST = 8'h01.
  - FSM state encoding: IDLE=2'b00, HEADER=2'b01, PAYLOAD=2'b10, DONE=2'b11, plus LENGTH=3'b100 when the feature is enabled (state register 3 bits then).
- One natural sub-module: auth_byte_mux, a combinational byte selector indexing header_snap/payload_snap by byte counter. The FSM, counters and handshake stay in the top.

Test Plan:
- Normal answer: header=32'h01_02_00_00, wLength=3, payload top bytes AA,BB,CC, Ack_in 0→1, tx_ready=1 → bytes 01,02,00,00,AA,BB,CC on 7 consecutive cycles starting 1 cycle after the edge; tx_last on CC; Resp_Sent pulses the following cycle.
- Backpressure: same stimulus, tx_ready low for 3 cycles on byte 2 → tx_data=00 held stable with tx_valid=1; no byte dropped or duplicated; total 10 cycles.
- Error path: Error_Invalid_Request=1 at the edge → bytes `PROTOCOL_VERSION, 7F, 01, 00; tx_last on byte 4; no payload.
- Clamp and zero length:
  - wLength=16'hFFFF → exactly PAYLOAD_BYTES payload bytes sent, len_clamped=1.
  - wLength=0 → 4 header bytes only, tx_last on byte 4.
- Reset mid-message: rst_n low while on payload byte 1 → tx_valid=0 and busy=0 immediately (asynchronous). After release with Ack_in still high, nothing is sent until Ack_in toggles 0→1.
- Held Ack / LEN_PREFIX:
  - Ack_in held high across two messages' worth of time → only one message sent.
  - With AUTH_SER_LEN_PREFIX_EN and wLength=3 → 03,00 inserted after the header bytes.
